seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Parametrised serial pattern detector; successor to the fixed all-ones detector FSM.
//  Detects a runtime-programmable, maskable PAT_W-bit pattern in a qualified serial bit
//  stream, in overlapping or non-overlapping mode. Sits between a serial front end and
//  event/interrupt logic; emits a one-cycle tick per match.
// PARAMETERS
//  PAT_W        8                  pattern length in bits; legal range >= 2
//  RST_PATTERN  {PAT_W{1'b1}}      pattern loaded at reset (all-ones = legacy behaviour)
//  CNT_W        16                 match counter width (only with SEQ_MATCH_CNT_EN)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  p            in   1      serial data bit
//  p_valid      in   1      p is sampled only on edges where p_valid=1
//  cfg_we       in   1      load cfg_* registers and flush history
//  cfg_pattern  in   PAT_W  pattern; bit PAT_W-1 = first (oldest) bit received
//  cfg_mask     in   PAT_W  1 = compare this bit, 0 = don't care
//  cfg_overlap  in   1      1 = overlapping matches, 0 = non-overlapping
//  clear        in   1      flush history (and match counter)
//  tick         out  1      registered match pulse, one cycle per match
//  armed        out  1      1 when PAT_W valid bits of history are held
//  match_cnt    out  CNT_W  saturating match count (only with SEQ_MATCH_CNT_EN)
// BEHAVIOUR
//  - Reset (async on rst_n low, all outputs immediate): pat=RST_PATTERN, mask=all ones,
//    overlap=1, sr=0, fill=0, tick=0, armed=0, match_cnt=0.
//  - History: sr[PAT_W-1:0]; on accepted bit sr <= {sr[PAT_W-2:0], p}; newest bit in LSB.
//  - fill 0..PAT_W: +1 per accepted bit, saturates at PAT_W; armed = (fill==PAT_W).
//  - State (derived from fill): FILL (fill<PAT_W) -> HUNT (fill==PAT_W).
//    FILL->HUNT on the PAT_W-th accepted bit. HUNT->FILL on a non-overlap match,
//    clear, or cfg_we. HUNT->HUNT otherwise.
//  - Match: accepted bit AND next fill==PAT_W AND ((next_sr ^ pat) & mask)==0.
//  - tick is registered at the same edge that accepts the completing bit: high in the
//    following cycle, for exactly one cycle. No tick on edges with p_valid=0.
//  - Overlap=1: history retained after match; continued stream may match on every bit
//    (all-ones pattern + all-ones stream -> tick on every bit after the 8th).
//  - Overlap=0: on match, sr<=0 and fill<=0; next match needs PAT_W fresh bits.
//  - p_valid=0 bubbles: hold sr/fill; sequence continuity is unaffected.
//  - Priority per edge: clear / cfg_we over p_valid. Bit offered that cycle is discarded;
//    tick<=0. clear+cfg_we together: config loaded AND full flush (incl. counter).
//  - cfg_we: pat/mask/overlap <= cfg_*; sr<=0, fill<=0; match_cnt retained.
//  - clear: sr<=0, fill<=0, match_cnt<=0; config retained.
//  - mask=0: every accepted bit in HUNT matches (overlap=1) or every PAT_W-th bit
//    (overlap=0).
//  - Async reset mid-sequence discards partial history; no tick until PAT_W new bits.
// CONFIGURATION
//  - SEQ_MATCH_CNT_EN defined: match_cnt port present; +1 on each match, saturates at
//    2^CNT_W-1; cleared by reset/clear only.
//  - Undefined: match_cnt port and counter logic absent; all other behaviour identical.
// TESTING
//  1. Defaults, p=1 with p_valid=1 for 10 bits -> tick on bits 8,9,10 only; armed from bit 8.
//  2. cfg pattern 8'hA5, mask 8'hFF, overlap=0; stream A5A5 MSB-first -> ticks at bits 8,16.
//  3. pattern 8'hAA, overlap=1; stream 1010... 12 bits -> ticks at bits 8,10,12.
//  4. Test 1 with p_valid=0 bubbles between each bit -> same 3 ticks; none in bubble cycles.
//  5. mask 8'h0F, pattern 8'h05; bytes 8'hF5 then 8'h35 (overlap=0) -> tick at bits 8,16.
//  6. 6 ones, rst_n low mid-cycle, release, 2 ones -> no tick; 8 more ones -> tick.
//  7. cfg_we with p_valid=1 at bit 7 of ones -> bit discarded, fill=0, no tick.
//  8. SEQ_MATCH_CNT_EN, CNT_W=2: 5 matches -> match_cnt=3; clear -> 0.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: programmable, maskable serial pattern detector with a one-cycle match tick
//
// Detects a PAT_W-bit pattern in a serial bit stream. A bit is taken only when p_valid is
// high. Matches may overlap or be non-overlapping, and cfg_mask selects which pattern bits
// are compared. The default configuration loaded at reset is the legacy all-ones detector.
//
// Optional feature: define SEQ_MATCH_CNT_EN to add a saturating match counter and the
// match_cnt port.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   p            serial data bit
//   p_valid      p is accepted on edges where this is high
//   cfg_we       load cfg_pattern/cfg_mask/cfg_overlap and flush history
//   cfg_pattern  pattern; bit PAT_W-1 is the oldest bit received
//   cfg_mask     1 = compare this bit, 0 = don't care
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   clear        flush history and match counter, keep configuration
//   match_cnt    saturating match count (SEQ_MATCH_CNT_EN only)
//   tick         registered match pulse, one cycle per match
//   armed        PAT_W valid history bits are held
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = {PAT_W{1'b1}}
`ifdef SEQ_MATCH_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p,
    input  logic             p_valid,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             clear,
`ifdef SEQ_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             tick,
    output logic             armed
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    localparam logic [FW-1:0] LAST = FW'(PAT_W - 1);

    typedef enum logic {FILL, HUNT} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] mask;
    logic             overlap;
    logic [PAT_W-1:0] sr;
    logic [PAT_W-1:0] sr_n;
    logic [PAT_W-1:0] shifted;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_n;
    logic             tick_n;
    logic             accept;
    logic             hit;

    // The fill count is the state register; HUNT simply means the history is full.
    assign state = (fill == FULL) ? HUNT : FILL;
    assign armed = (state == HUNT);

    always_comb begin
        accept  = p_valid & ~clear & ~cfg_we;
        shifted = (sr << 1) | PAT_W'(p);
        // After this bit the history is full if it already was, or if this is the PAT_W-th bit.
        hit     = accept && (state == HUNT || fill == LAST) && (((shifted ^ pat) & mask) == '0);
        sr_n    = sr;
        fill_n  = fill;
        tick_n  = 1'b0;
        if (clear || cfg_we) begin
            sr_n   = '0;
            fill_n = '0;
        end else if (accept) begin
            sr_n   = (hit && !overlap) ? '0 : shifted;
            fill_n = (hit && !overlap) ? '0 : ((state == HUNT) ? fill : fill + 1'b1);
            tick_n = hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat     <= RST_PATTERN;
            mask    <= '1;
            overlap <= 1'b1;
            sr      <= '0;
            fill    <= '0;
            tick    <= 1'b0;
        end else begin
            sr   <= sr_n;
            fill <= fill_n;
            tick <= tick_n;
            if (cfg_we) begin
                pat     <= cfg_pattern;
                mask    <= cfg_mask;
                overlap <= cfg_overlap;
            end
        end
    end

`ifdef SEQ_MATCH_CNT_EN
    // cfg_we alone keeps the count; only reset and clear zero it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) match_cnt <= '0;
        else if (clear) match_cnt <= '0;
        else if (hit && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: table-driven scoreboard bench for seq_detect_param
module tb_seq_detect_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       p = 1'b0;
    logic       p_valid = 1'b0;
    logic       cfg_we = 1'b0;
    logic       clear = 1'b0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [7:0] cfg_mask = 8'h00;
    logic       tick;
    logic       armed;
`ifdef SEQ_MATCH_CNT_EN
    logic [1:0] match_cnt;
`endif

    always #5 clk = ~clk;

`ifdef SEQ_MATCH_CNT_EN
    seq_detect_param #(.PAT_W(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .p(p), .p_valid(p_valid), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
        .clear(clear), .match_cnt(match_cnt), .tick(tick), .armed(armed));
`else
    seq_detect_param #(.PAT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .p(p), .p_valid(p_valid), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
        .clear(clear), .tick(tick), .armed(armed));
`endif

    typedef struct {
        logic pv;
        logic b;
        logic clr;
        logic we;
        logic tick;
        logic armed;
        int   tag;
    } vec_t;

    typedef struct {
        logic tick;
        logic armed;
        int   tag;
        int   idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic pv, input logic b, input logic clr, input logic we,
                                input logic tk, input logic ar, input int tag);
        vec_t v;
        v.pv = pv; v.b = b; v.clr = clr; v.we = we; v.tick = tk; v.armed = ar; v.tag = tag;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl();
        exp_t e;
        exp_t d;
        foreach (tbl[i]) begin
            @(negedge clk);
            p_valid = tbl[i].pv;
            p       = tbl[i].b;
            clear   = tbl[i].clr;
            cfg_we  = tbl[i].we;
            d.tick = tbl[i].tick; d.armed = tbl[i].armed; d.tag = tbl[i].tag; d.idx = i;
            sb.push_back(d);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("t%0d[%0d] tick", e.tag, e.idx), 32'(tick), 32'(e.tick));
            chk($sformatf("t%0d[%0d] armed", e.tag, e.idx), 32'(armed), 32'(e.armed));
        end
        @(negedge clk);
        p_valid = 1'b0; p = 1'b0; clear = 1'b0; cfg_we = 1'b0;
        tbl.delete();
    endtask

    task automatic set_cfg(input logic [7:0] pat, input logic [7:0] msk, input logic ov);
        cfg_pattern = pat;
        cfg_mask    = msk;
        cfg_overlap = ov;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] s16;
        logic [23:0] s24;
        #12;
        chk("reset tick", 32'(tick), 0);
        chk("reset armed", 32'(armed), 0);
`ifdef SEQ_MATCH_CNT_EN
        chk("reset cnt", 32'(match_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Reset defaults: all-ones overlapping detector
        for (int k = 1; k <= 10; k++) add(1, 1, 0, 0, k >= 8, k >= 8, 1);
        add(0, 0, 1, 0, 0, 0, 1);
        run_tbl();

        // Bubbles between bits must not disturb continuity or produce ticks
        for (int k = 1; k <= 10; k++) begin
            add(1, 1, 0, 0, k >= 8, k >= 8, 4);
            add(0, 1, 0, 0, 0, k >= 8, 4);
        end
        add(0, 0, 1, 0, 0, 0, 4);
        run_tbl();

        // cfg_we at bit 7 discards the bit; clear beats p_valid
        set_cfg(8'hFF, 8'hFF, 1'b1);
        for (int k = 1; k <= 6; k++) add(1, 1, 0, 0, 0, 0, 7);
        add(1, 1, 0, 1, 0, 0, 7);
        for (int k = 1; k <= 8; k++) add(1, 1, 0, 0, k == 8, k == 8, 7);
        add(0, 0, 1, 0, 0, 0, 7);
        for (int k = 1; k <= 7; k++) add(1, 1, 0, 0, 0, 0, 7);
        add(1, 1, 1, 0, 0, 0, 7);
        for (int k = 1; k <= 8; k++) add(1, 1, 0, 0, k == 8, k == 8, 7);
        run_tbl();

        // A5 non-overlapping
        set_cfg(8'hA5, 8'hFF, 1'b0);
        add(0, 0, 0, 1, 0, 0, 2);
        s16 = 16'hA5A5;
        for (int k = 1; k <= 16; k++) add(1, s16[16-k], 0, 0, k == 8 || k == 16, 0, 2);
        run_tbl();

        // AA overlapping on alternating stream
        set_cfg(8'hAA, 8'hFF, 1'b1);
        add(0, 0, 0, 1, 0, 0, 3);
        for (int k = 1; k <= 12; k++) add(1, k % 2 == 1, 0, 0, k >= 8 && k % 2 == 0, k >= 8, 3);
        run_tbl();

        // Masked low nibble, non-overlapping; third byte misses in the compared nibble
        set_cfg(8'h05, 8'h0F, 1'b0);
        add(0, 0, 0, 1, 0, 0, 5);
        s24 = 24'hF53534;
        for (int k = 1; k <= 24; k++) add(1, s24[24-k], 0, 0, k == 8 || k == 16, k == 24, 5);
        run_tbl();

        // Empty mask: every PAT_W-th bit non-overlapping, every bit once full when overlapping
        set_cfg(8'h00, 8'h00, 1'b0);
        add(0, 0, 0, 1, 0, 0, 9);
        for (int k = 1; k <= 16; k++) add(1, k % 2 == 0, 0, 0, k == 8 || k == 16, 0, 9);
        run_tbl();
        set_cfg(8'h00, 8'h00, 1'b1);
        add(0, 0, 0, 1, 0, 0, 10);
        for (int k = 1; k <= 10; k++) add(1, k % 3 == 0, 0, 0, k >= 8, k >= 8, 10);
        run_tbl();

        // Async reset mid-sequence discards history and restores defaults
        set_cfg(8'hFF, 8'hFF, 1'b1);
        add(0, 0, 0, 1, 0, 0, 6);
        for (int k = 1; k <= 6; k++) add(1, 1, 0, 0, 0, 0, 6);
        run_tbl();
        p_valid = 1'b1;
        p = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6 in-reset armed", 32'(armed), 0);
        @(negedge clk);
        rst_n = 1'b1;
        p_valid = 1'b0;
        for (int k = 1; k <= 10; k++) add(1, 1, 0, 0, k >= 8, k >= 8, 6);
        run_tbl();
        chk("t6 tick before reset", 32'(tick), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6 async tick", 32'(tick), 0);
        chk("t6 async armed", 32'(armed), 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SEQ_MATCH_CNT_EN
        // Counter saturates at 3, survives cfg_we, zeroed by clear
        for (int k = 1; k <= 12; k++) add(1, 1, 0, 0, k >= 8, k >= 8, 8);
        run_tbl();
        chk("t8 cnt saturated", 32'(match_cnt), 3);
        add(0, 0, 0, 1, 0, 0, 8);
        run_tbl();
        chk("t8 cnt after cfg_we", 32'(match_cnt), 3);
        add(0, 0, 1, 0, 0, 0, 8);
        run_tbl();
        chk("t8 cnt after clear", 32'(match_cnt), 0);
`endif

        chk("scoreboard drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
